// File: rtl/evm_session_controller.sv
// Polling-session sequencer for the EVM: officer authentication, voter lookup,
// repeat-voter blocking, timed ballot and saturating per-candidate tallies.
module evm_session_controller #(
  parameter int ADDRESS_SIZE   = 4,
  parameter int NUM_CAND       = 4,
  parameter int COUNT_WIDTH    = 8,
  parameter int LOOKUP_TIMEOUT = 8,
  parameter int BALLOT_TIMEOUT = 64,
  localparam int SEL_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    officer_login,
  input  logic                    voter_req,
  input  logic                    close_session,
  input  logic                    db_done,
  input  logic                    officer_ok,
  input  logic                    reset_ok,
  input  logic                    voter_ok,
  input  logic [ADDRESS_SIZE-1:0] voter_addr,
  input  logic [NUM_CAND-1:0]     cand_sel,
  input  logic [SEL_W-1:0]        count_sel,
  output logic                    db_read_enable,
  output logic                    session_active,
  output logic                    ballot_open,
  output logic                    vote_accepted,
  output logic                    reject,
  output logic [1:0]              reject_code,
  output logic [COUNT_WIDTH-1:0]  count_out
);

  localparam int NUM_ADDR = 2 ** ADDRESS_SIZE;
  localparam int TMAX     = (LOOKUP_TIMEOUT > BALLOT_TIMEOUT) ? LOOKUP_TIMEOUT : BALLOT_TIMEOUT;
  localparam int TIMER_W  = $clog2(TMAX + 1);
  localparam logic [TIMER_W-1:0] LOOKUP_LAST = TIMER_W'(LOOKUP_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] BALLOT_LAST = TIMER_W'(BALLOT_TIMEOUT - 1);

  localparam logic [1:0] CODE_BAD_ID  = 2'b01;
  localparam logic [1:0] CODE_VOTED   = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {IDLE, AUTH_WAIT, READY, LOOKUP, BALLOT, COMMIT} state_e;

  state_e                   state_q;
  logic [TIMER_W-1:0]       timer_q;
  logic [ADDRESS_SIZE-1:0]  voterAddr_q;
  logic [SEL_W-1:0]         candIdx_q;
  logic [NUM_ADDR-1:0]      voted_q;
  logic [COUNT_WIDTH-1:0]   tally_q [NUM_CAND];

  logic                     candOneHot;
  logic [SEL_W-1:0]         candIdx;

  always_comb begin
    candIdx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cand_sel[i]) candIdx = SEL_W'(i);
    end
  end

  assign candOneHot = (cand_sel != '0) && ((cand_sel & (cand_sel - NUM_CAND'(1))) == '0);
  assign count_out  = tally_q[count_sel];

  // Outputs are loaded alongside the state so they always match the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      voterAddr_q    <= '0;
      candIdx_q      <= '0;
      voted_q        <= '0;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      db_read_enable <= 1'b0;
      session_active <= 1'b0;
      ballot_open    <= 1'b0;
      vote_accepted  <= 1'b0;
      reject         <= 1'b0;
      reject_code    <= 2'b00;
    end else begin
      db_read_enable <= 1'b0;
      vote_accepted  <= 1'b0;
      reject         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (officer_login) begin
            state_q        <= AUTH_WAIT;
            timer_q        <= '0;
            db_read_enable <= 1'b1;
          end
        end
        AUTH_WAIT: begin
          if (db_done) begin
            if (reset_ok) begin
              state_q <= IDLE;
              voted_q <= '0;
              for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
            end else if (officer_ok) begin
              state_q        <= READY;
              session_active <= 1'b1;
            end else begin
              state_q     <= IDLE;
              reject      <= 1'b1;
              reject_code <= CODE_BAD_ID;
            end
          end else if (timer_q == LOOKUP_LAST) begin
            state_q     <= IDLE;
            reject      <= 1'b1;
            reject_code <= CODE_TIMEOUT;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        READY: begin
          if (close_session) begin
            state_q        <= IDLE;
            session_active <= 1'b0;
          end else if (voter_req) begin
            state_q        <= LOOKUP;
            timer_q        <= '0;
            db_read_enable <= 1'b1;
          end
        end
        LOOKUP: begin
          if (db_done) begin
            if (voter_ok && !voted_q[voter_addr]) begin
              state_q     <= BALLOT;
              voterAddr_q <= voter_addr;
              timer_q     <= '0;
              ballot_open <= 1'b1;
            end else begin
              state_q     <= READY;
              reject      <= 1'b1;
              reject_code <= voter_ok ? CODE_VOTED : CODE_BAD_ID;
            end
          end else if (timer_q == LOOKUP_LAST) begin
            state_q     <= READY;
            reject      <= 1'b1;
            reject_code <= CODE_TIMEOUT;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        BALLOT: begin
          if (candOneHot) begin
            state_q     <= COMMIT;
            candIdx_q   <= candIdx;
            ballot_open <= 1'b0;
          end else if (timer_q == BALLOT_LAST) begin
            state_q     <= READY;
            ballot_open <= 1'b0;
            reject      <= 1'b1;
            reject_code <= CODE_TIMEOUT;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        COMMIT: begin
          if (tally_q[candIdx_q] != '1) tally_q[candIdx_q] <= tally_q[candIdx_q] + COUNT_WIDTH'(1);
          voted_q[voterAddr_q] <= 1'b1;
          vote_accepted        <= 1'b1;
          state_q              <= READY;
        end
        default: begin
          state_q        <= IDLE;
          session_active <= 1'b0;
          ballot_open    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_evm_session_controller.sv
// Self-checking bench for evm_session_controller: directed session scenarios plus
// randomized voter traffic scored against a tally/bitmap model; a 2-bit-tally copy checks saturation.
`timescale 1ns/1ps
module tb_evm_session_controller;

  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       officer_login = 1'b0, voter_req = 1'b0, close_session = 1'b0;
  logic       db_done = 1'b0, officer_ok = 1'b0, reset_ok = 1'b0, voter_ok = 1'b0;
  logic [3:0] voter_addr = '0;
  logic [3:0] cand_sel = '0;
  logic [1:0] count_sel = '0;

  logic       db_read_enable, session_active, ballot_open, vote_accepted, reject;
  logic [1:0] reject_code;
  logic [7:0] count_out;

  logic       bDbRe, bSess, bBallot, bAcc, bRej;
  logic [1:0] bCode;
  logic [1:0] bCount;

  int compareCount = 0;
  int failCount = 0;
  int tallyM [NC];
  bit votedM [16];
  int lastCode = 0;

  evm_session_controller dut (
    .clk(clk), .reset_n(reset_n), .officer_login(officer_login), .voter_req(voter_req),
    .close_session(close_session), .db_done(db_done), .officer_ok(officer_ok),
    .reset_ok(reset_ok), .voter_ok(voter_ok), .voter_addr(voter_addr), .cand_sel(cand_sel),
    .count_sel(count_sel), .db_read_enable(db_read_enable), .session_active(session_active),
    .ballot_open(ballot_open), .vote_accepted(vote_accepted), .reject(reject),
    .reject_code(reject_code), .count_out(count_out)
  );

  evm_session_controller #(.COUNT_WIDTH(2)) dutSat (
    .clk(clk), .reset_n(reset_n), .officer_login(officer_login), .voter_req(voter_req),
    .close_session(close_session), .db_done(db_done), .officer_ok(officer_ok),
    .reset_ok(reset_ok), .voter_ok(voter_ok), .voter_addr(voter_addr), .cand_sel(cand_sel),
    .count_sel(count_sel), .db_read_enable(bDbRe), .session_active(bSess),
    .ballot_open(bBallot), .vote_accepted(bAcc), .reject(bRej),
    .reject_code(bCode), .count_out(bCount)
  );

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before the summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] randomInvalid();
    logic [3:0] v;
    do v = 4'($urandom_range(0, 15)); while ($countones(v) == 1);
    return v;
  endfunction

  task automatic clearModel();
    for (int c = 0; c < NC; c++) tallyM[c] = 0;
    for (int a = 0; a < 16; a++) votedM[a] = 1'b0;
  endtask

  task automatic checkTallies(input string tag);
    for (int c = 0; c < NC; c++) begin
      count_sel = 2'(c);
      #1;
      checkOutput($sformatf("%s_tally%0d", tag, c), 32'(count_out), 32'((tallyM[c] > 255) ? 255 : tallyM[c]));
      checkOutput($sformatf("%s_sat%0d", tag, c), 32'(bCount), 32'((tallyM[c] > 3) ? 3 : tallyM[c]));
    end
  endtask

  task automatic login(input bit useReset, input bit officerGood);
    officer_login = 1'b1;
    tick();
    officer_login = 1'b0;
    checkOutput("login_strobe", 32'(db_read_enable), 1);
    tick();
    checkOutput("login_strobe_end", 32'(db_read_enable), 0);
    db_done = 1'b1; reset_ok = useReset; officer_ok = officerGood;
    tick();
    db_done = 1'b0; reset_ok = 1'b0; officer_ok = 1'b0;
    if (useReset) begin
      clearModel();
      checkOutput("reset_login_session", 32'(session_active), 0);
      checkOutput("reset_login_reject", 32'(reject), 0);
      checkTallies("reset_login");
    end else if (officerGood) begin
      checkOutput("login_session", 32'(session_active), 1);
      checkOutput("login_reject", 32'(reject), 0);
    end else begin
      lastCode = 1;
      checkOutput("bad_officer_session", 32'(session_active), 0);
      checkOutput("bad_officer_reject", 32'(reject), 1);
      checkOutput("bad_officer_code", 32'(reject_code), 1);
    end
    tick();
    checkOutput("login_reject_end", 32'(reject), 0);
  endtask

  task automatic lookup(input logic [3:0] addr, input bit ok);
    voter_req = 1'b1;
    tick();
    voter_req = 1'b0;
    checkOutput("lookup_strobe", 32'(db_read_enable), 1);
    tick();
    db_done = 1'b1; voter_ok = ok; voter_addr = addr;
    tick();
    db_done = 1'b0; voter_ok = 1'b0;
  endtask

  // One voter transaction: lookup, optional invalid button presses, then a single valid press.
  task automatic applyStimulus(input logic [3:0] addr, input bit ok, input int cand, input int junk);
    lookup(addr, ok);
    if (!ok) begin
      lastCode = 1;
      checkOutput("bad_voter_reject", 32'(reject), 1);
      checkOutput("bad_voter_code", 32'(reject_code), 1);
      checkOutput("bad_voter_ballot", 32'(ballot_open), 0);
    end else if (votedM[addr]) begin
      lastCode = 2;
      checkOutput("repeat_reject", 32'(reject), 1);
      checkOutput("repeat_code", 32'(reject_code), 2);
      checkOutput("repeat_ballot", 32'(ballot_open), 0);
    end else begin
      checkOutput("ballot_open", 32'(ballot_open), 1);
      checkOutput("ballot_no_reject", 32'(reject), 0);
      for (int j = 0; j < junk; j++) begin
        cand_sel = randomInvalid();
        tick();
        checkOutput("junk_ignored", 32'(ballot_open), 1);
      end
      cand_sel = 4'(1 << cand);
      tick();
      cand_sel = '0;
      checkOutput("commit_ballot_closed", 32'(ballot_open), 0);
      tick();
      checkOutput("vote_accepted", 32'(vote_accepted), 1);
      checkOutput("code_held", 32'(reject_code), 32'(lastCode));
      tallyM[cand]++;
      votedM[addr] = 1'b1;
      checkTallies("vote");
    end
    tick();
    checkOutput("pulse_end", 32'(reject | vote_accepted), 0);
  endtask

  initial begin
    int k;
    int n;
    clearModel();

    #2 reset_n = 1'b0;
    #2;
    checkOutput("reset_session", 32'(session_active), 0);
    checkOutput("reset_outputs", 32'({db_read_enable, ballot_open, vote_accepted, reject, reject_code}), 0);
    checkTallies("reset");
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    voter_req = 1'b1; close_session = 1'b1;
    tick();
    voter_req = 1'b0; close_session = 1'b0;
    checkOutput("idle_ignores_voter_req", 32'(db_read_enable | session_active), 0);

    login(1'b0, 1'b0);

    officer_login = 1'b1;
    tick();
    officer_login = 1'b0;
    k = 0;
    while (k < 20) begin
      tick();
      k++;
      if (reject) break;
    end
    lastCode = 3;
    checkOutput("auth_timeout_cycles", 32'(k), 8);
    checkOutput("auth_timeout_code", 32'(reject_code), 3);
    checkOutput("auth_timeout_session", 32'(session_active), 0);
    tick();

    login(1'b0, 1'b1);
    applyStimulus(4'd3, 1'b1, 1, 0);
    applyStimulus(4'd3, 1'b1, 2, 0);
    applyStimulus(4'd4, 1'b0, 0, 0);

    lookup(4'd7, 1'b1);
    checkOutput("timeout_ballot_open", 32'(ballot_open), 1);
    n = 1;
    while (n < 100) begin
      tick();
      if (!ballot_open) break;
      n++;
    end
    lastCode = 3;
    checkOutput("ballot_open_cycles", 32'(n), 64);
    checkOutput("ballot_timeout_reject", 32'(reject), 1);
    checkOutput("ballot_timeout_code", 32'(reject_code), 3);
    tick();
    applyStimulus(4'd7, 1'b1, 3, 0);

    lookup(4'd8, 1'b1);
    cand_sel = 4'b0110;
    tick();
    checkOutput("multi_press_ignored", 32'(ballot_open), 1);
    cand_sel = 4'b0100;
    tick();
    cand_sel = '0;
    tick();
    checkOutput("single_press_accepted", 32'(vote_accepted), 1);
    tallyM[2]++;
    votedM[8] = 1'b1;
    checkTallies("multi_then_single");
    tick();

    voter_req = 1'b1;
    tick();
    voter_req = 1'b0;
    k = 0;
    while (k < 20) begin
      tick();
      k++;
      if (reject) break;
    end
    lastCode = 3;
    checkOutput("lookup_timeout_cycles", 32'(k), 8);
    checkOutput("lookup_timeout_code", 32'(reject_code), 3);
    checkOutput("lookup_timeout_session", 32'(session_active), 1);
    tick();

    voter_req = 1'b1;
    tick();
    voter_req = 1'b0;
    repeat (7) tick();
    db_done = 1'b1; voter_ok = 1'b1; voter_addr = 4'd9;
    tick();
    db_done = 1'b0; voter_ok = 1'b0;
    checkOutput("expiry_db_done_wins", 32'(ballot_open), 1);
    checkOutput("expiry_no_reject", 32'(reject), 0);
    cand_sel = 4'b0001;
    tick();
    cand_sel = '0;
    tick();
    checkOutput("expiry_vote_accepted", 32'(vote_accepted), 1);
    tallyM[0]++;
    votedM[9] = 1'b1;
    tick();

    close_session = 1'b1; voter_req = 1'b1;
    tick();
    close_session = 1'b0; voter_req = 1'b0;
    checkOutput("close_wins_session", 32'(session_active), 0);
    checkOutput("close_wins_strobe", 32'(db_read_enable), 0);
    login(1'b0, 1'b1);
    checkTallies("persist");

    for (int t = 0; t < 24; t++) begin
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, NC - 1)), int'($urandom_range(0, 5)));
    end

    close_session = 1'b1;
    tick();
    close_session = 1'b0;
    checkOutput("close_session", 32'(session_active), 0);
    login(1'b1, 1'b1);
    login(1'b0, 1'b1);
    for (int a = 10; a < 15; a++) applyStimulus(4'(a), 1'b1, 0, 0);
    checkTallies("saturate");

    lookup(4'd2, 1'b1);
    checkOutput("pre_reset_ballot", 32'(ballot_open), 1);
    reset_n = 1'b0;
    #1;
    clearModel();
    checkOutput("midballot_reset_ballot", 32'(ballot_open | bBallot), 0);
    checkOutput("midballot_reset_session", 32'(session_active | bSess), 0);
    checkTallies("midballot_reset");
    tick();
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
